// File: rtl/demux_1to2_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_1to2_buf_pkg
// Description : Shared constants and types for the buffered 1-to-2 demux.
//               Holds the delivered-beat counter width, the supported channel
//               buffer depths and the derived pointer/occupancy widths.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_1to2_buf_pkg;

    // Width of the per-channel delivered-beat counters
    localparam int CNT_WIDTH = 16;

    // Supported channel buffer depths
    localparam int DEPTH_SMALL = 2;
    localparam int DEPTH_LARGE = 4;

    // Destination channel encoding of the select input
    typedef enum logic {
        CHAN_0 = 1'b0,
        CHAN_1 = 1'b1
    } chan_e;

    // True when the depth is one of the supported buffer sizes
    function automatic bit depth_is_legal(input int depth);
        return (depth == DEPTH_SMALL) || (depth == DEPTH_LARGE);
    endfunction

    // Pointer width needed to address a buffer of the given depth
    function automatic int ptr_width(input int depth);
        return (depth == DEPTH_LARGE) ? 2 : 1;
    endfunction

    // Occupancy width needed to represent 0..depth inclusive
    function automatic int occ_width(input int depth);
        return (depth == DEPTH_LARGE) ? 3 : 2;
    endfunction

endpackage : demux_1to2_buf_pkg
`default_nettype wire

// File: rtl/demux_chan_fifo.sv
`default_nettype none
// ============================================================================
// Module      : demux_chan_fifo
// Description : One output channel of the demux. DEPTH-entry in-order FIFO
//               with registered head output, full/valid status and a
//               wrapping counter of beats delivered downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_chan_fifo
    import demux_1to2_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_push,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_full,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int OCC_W = occ_width(DEPTH);

    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] C_FULL_OCC = OCC_W'(DEPTH);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [OCC_W-1:0]     r_occ;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_do_push;
    logic                 w_do_pop;
    logic [PTR_W-1:0]     w_wr_ptr_nxt;
    logic [PTR_W-1:0]     w_rd_ptr_nxt;

    // Status, transfer qualification and pointer wrap arithmetic
    always_comb begin
        w_empty      = (r_occ == '0);
        w_full       = (r_occ == C_FULL_OCC);
        // A full buffer refuses pushes even when it is popped this cycle
        w_do_push    = i_push & ~w_full;
        // Downstream ready is ignored while nothing is buffered
        w_do_pop     = i_ready & ~w_empty;
        w_wr_ptr_nxt = (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_nxt = (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
    end

    // Storage write; async reset clears every entry so the head reads zero
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Write/read pointers advance independently on push and pop
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
        end
    end

    // Occupancy tracking; simultaneous push and pop leaves it unchanged
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_occ <= '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Delivered-beat counter, wraps naturally at its full width
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (w_do_pop) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_valid = ~w_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_cnt   = r_cnt;

endmodule : demux_chan_fifo
`default_nettype wire

// File: rtl/demux_1to2_buf.sv
`default_nettype none
// ============================================================================
// Module      : demux_1to2_buf
// Description : Buffered 1-to-2 demultiplexer. An input beat is routed to
//               channel 0 or 1 by i_sel and queued in that channel's FIFO.
//               Input ready depends only on the selected channel's fullness,
//               so there is no combinational path from downstream ready.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1to2_buf
    import demux_1to2_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_sel,
    output logic                 o_ready,
    output logic                 o_valid0,
    output logic [WIDTH-1:0]     o_data0,
    input  logic                 i_ready0,
    output logic [CNT_WIDTH-1:0] o_cnt0,
    output logic                 o_valid1,
    output logic [WIDTH-1:0]     o_data1,
    input  logic                 i_ready1,
    output logic [CNT_WIDTH-1:0] o_cnt1
);

    logic w_full0;
    logic w_full1;
    logic w_sel_full;
    logic w_accept;
    logic w_push0;
    logic w_push1;

    // Select decode: ready follows the selected channel, push goes to it only
    always_comb begin
        w_sel_full = (i_sel == CHAN_1) ? w_full1 : w_full0;
        o_ready    = ~w_sel_full;
        w_accept   = i_valid & ~w_sel_full;
        w_push0    = w_accept & (i_sel == CHAN_0);
        w_push1    = w_accept & (i_sel == CHAN_1);
    end

    demux_chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_chan0 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push0),
        .i_data  (i_data),
        .i_ready (i_ready0),
        .o_valid (o_valid0),
        .o_data  (o_data0),
        .o_full  (w_full0),
        .o_cnt   (o_cnt0)
    );

    demux_chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_chan1 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push1),
        .i_data  (i_data),
        .i_ready (i_ready1),
        .o_valid (o_valid1),
        .o_data  (o_data1),
        .o_full  (w_full1),
        .o_cnt   (o_cnt1)
    );

endmodule : demux_1to2_buf
`default_nettype wire

// File: doc/demux_1to2_buf.md
DEMUX_1TO2_BUF -- requirements
Module: demux_1to2_buf

Interface
REQ-001 Parameter WIDTH, default 32, data width of the input and both output channels.
REQ-002 Parameter DEPTH, default 2, entries per output channel buffer; legal values 2 and 4.
REQ-003 i_clk  input  1  single clock, all state updates on rising edge.
REQ-004 i_reset  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 i_valid  input  1  input beat present.
REQ-006 i_data  input  WIDTH  input beat payload.
REQ-007 i_sel  input  1  destination select: 0 routes to channel 0, 1 routes to channel 1.
REQ-008 o_ready  output  1  block accepts the input beat this cycle.
REQ-009 o_valid0 / o_valid1  output  1  channel 0 / channel 1 has a beat at its head.
REQ-010 o_data0 / o_data1  output  WIDTH  head payload of channel 0 / channel 1.
REQ-011 i_ready0 / i_ready1  input  1  downstream of channel 0 / channel 1 consumes the head beat.
REQ-012 o_cnt0 / o_cnt1  output  16  count of beats delivered on channel 0 / channel 1.

Function
REQ-013 Input transfer occurs when i_valid=1 and o_ready=1 at the rising edge; output transfer on channel k occurs when o_valid_k=1 and i_ready_k=1.
REQ-014 o_ready = NOT full(channel selected by i_sel); it is independent of i_ready0/i_ready1 (no combinational ready path from downstream).
REQ-015 An accepted beat is written into the selected channel FIFO only; the other channel is unaffected.
REQ-016 Latency: a beat accepted at edge N is visible on o_valid_k/o_data_k after edge N (one-cycle registered latency), with no combinational path from i_data to o_data_k.
REQ-017 Each channel is an in-order FIFO of DEPTH entries; beats on one channel never reorder; channels drain independently.
REQ-018 Channel occupancy counts 0..DEPTH; o_valid_k = (occupancy_k != 0); o_data_k = entry at the read pointer.
REQ-019 Simultaneous push and pop on the same channel: occupancy unchanged, both pointers advance.
REQ-020 Full channel: push refused (o_ready=0 while selected) even if a pop occurs in the same cycle.
REQ-021 Empty channel: i_ready_k ignored; no pointer move, no counter change.
REQ-022 Read/write pointers wrap modulo DEPTH.
REQ-023 o_cnt_k increments by 1 on each output transfer on channel k and wraps 16'hFFFF -> 16'h0000.
REQ-024 i_sel and i_data are sampled only on input transfer; changing them while o_ready=0 has no effect.

Reset
REQ-025 While i_reset=0: occupancies, pointers, o_cnt0, o_cnt1 = 0; o_valid0 = o_valid1 = 0; o_data0 = o_data1 = 0; storage cleared.
REQ-026 Reset asserted mid-operation discards all buffered beats immediately (asynchronous), without waiting for a clock edge.
REQ-027 First transfer possible on the first rising edge after i_reset deasserts; o_ready = 1 after reset.

Structure
REQ-028 Shared package holds the counter width constant (16) and allowed DEPTH values; WIDTH stays a module parameter.
REQ-029 One sub-module, demux_chan_fifo (DEPTH-entry FIFO with push/pop/full/empty, delivered-beat counter), instantiated twice.
REQ-030 Top level holds only the select decode and o_ready generation.

Verification
REQ-031 Reset, then push 0xA5A5_0001 with i_sel=0, i_ready0=1 -> o_valid0=1, o_data0=0xA5A5_0001 next cycle, o_valid1=0, o_cnt0=1 after consume.
REQ-032 i_ready1=0, push 0x11,0x22 on ch1 (DEPTH=2) -> o_ready=0 with i_sel=1, o_ready=1 with i_sel=0; then i_ready1=1 -> 0x11 then 0x22 in order.
REQ-033 Ch0 full, same-cycle pop and push attempt -> push refused, occupancy drops to 1, o_ready=1 next cycle.
REQ-034 Alternate i_sel 0,1,0,1 with data 1..4, both ready=1 -> ch0 delivers 1,3; ch1 delivers 2,4; o_cnt0=o_cnt1=2.
REQ-035 Buffer 2 beats on ch0, assert i_reset=0 between edges -> o_valid0=0, o_data0=0, o_cnt0=0 immediately.
REQ-036 Deliver 65537 beats on ch1 -> o_cnt1=1 (wrap).
